// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: digit data/blink in, segment/anode/frame out
interface seven_seg_scanner_if;
  logic [15:0] Qdata;
  logic [3:0] blink;
  logic [6:0] seg;
  logic [3:0] an;
  logic frame;
  modport master(output Qdata, blink, input seg, an, frame);
  modport slave(input Qdata, blink, output seg, an, frame);
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexes four BCD digits with per-digit blink and leading-zero blanking
module seven_seg_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int BLINK_TICKS = 250,
  parameter bit LZ_BLANK = 1
) (
  input logic clk,
  input logic rst,
  seven_seg_scanner_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
  logic [PW-1:0] pre;
  logic [BW-1:0] bcnt;
  logic [1:0] idx;
  logic phase, frame, tick, bwrap, blank;
  logic [15:0] sq;
  logic [3:0] sb, an, dig, sup;
  logic [6:0] seg;
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: decode = 7'h40;
      4'd1: decode = 7'h79;
      4'd2: decode = 7'h24;
      4'd3: decode = 7'h30;
      4'd4: decode = 7'h19;
      4'd5: decode = 7'h12;
      4'd6: decode = 7'h02;
      4'd7: decode = 7'h78;
      4'd8: decode = 7'h00;
      4'd9: decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction
  always_comb begin
    tick = pre == PW'(SCAN_DIV - 1);
    bwrap = bcnt == BW'(BLINK_TICKS - 1);
    dig = sq[{idx, 2'b00} +: 4];
    // a digit is a leading zero when it and every digit to its left is zero
    sup = LZ_BLANK ? {sq[15:12] == 4'd0, sq[15:8] == 8'd0, sq[15:4] == 12'd0, 1'b0} : 4'b0;
    blank = sup[idx] || (sb[idx] && !phase);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre <= '0;
      idx <= '0;
      bcnt <= '0;
      phase <= 1'b1;
      sq <= '0;
      sb <= '0;
      frame <= 1'b0;
      an <= 4'hF;
      seg <= 7'h7F;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      frame <= tick && idx == 2'd3;
      an <= blank ? 4'hF : ~(4'b0001 << idx);
      seg <= blank ? 7'h7F : decode(dig);
      if (tick) begin
        idx <= idx + 1'b1;
        bcnt <= bwrap ? '0 : bcnt + 1'b1;
        phase <= phase ^ bwrap;
        if (idx == 2'd3) begin
          sq <= bus.Qdata;
          sb <= bus.blink;
        end
      end
    end
  end
  assign bus.seg = seg;
  assign bus.an = an;
  assign bus.frame = frame;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed scoreboard bench for two scanner instances (LZ_BLANK 1 and 0)
module tb_seven_seg_scanner;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] qd = 16'h0;
  logic [3:0] bl = 4'h0;
  int vecs = 0;
  int errs = 0;
  int f = 0;
  logic [15:0] shq = 16'h0;
  logic [3:0] shb = 4'h0;
  logic [21:0] sbq[$];
  always #5 clk = ~clk;
  seven_seg_scanner_if b1();
  seven_seg_scanner_if b0();
  assign b1.Qdata = qd;
  assign b1.blink = bl;
  assign b0.Qdata = qd;
  assign b0.blink = bl;
  seven_seg_scanner #(.SCAN_DIV(4), .BLINK_TICKS(8), .LZ_BLANK(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  seven_seg_scanner #(.SCAN_DIV(4), .BLINK_TICKS(8), .LZ_BLANK(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  function automatic logic [6:0] lut(input logic [3:0] d);
    logic [6:0] t[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    return t[d];
  endfunction
  function automatic logic [10:0] exp_out(input logic [15:0] q, input logic [3:0] b, input logic ph,
                                          input int k, input bit lz);
    logic sup;
    sup = lz && k > 0 && (q >> (4 * k)) == 16'h0;
    if (sup || (b[k] && !ph)) return {4'hF, 7'h7F};
    return {~4'(1 << k), lut(q[k*4 +: 4])};
  endfunction
  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_lz1", {b1.an, b1.seg}, {4'hF, 7'h7F});
    chk("rst_lz0", {b0.an, b0.seg}, {4'hF, 7'h7F});
    chk("rst_frame", {10'd0, b1.frame | b0.frame}, 11'd0);
    rst = 1'b1;
    f = 0;
    shq = 16'h0;
    shb = 4'h0;
    sbq.delete();
  endtask
  // one displayed frame: 16 output cycles, ending on the next capture pulse
  task automatic check_frame(input logic [15:0] nq, input int at);
    logic ph;
    logic [21:0] e;
    ph = ((f / 2) % 2) == 0;
    for (int i = 0; i < 16; i++)
      sbq.push_back({exp_out(shq, shb, ph, i / 4, 1'b1), exp_out(shq, shb, ph, i / 4, 1'b0)});
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      e = sbq.pop_front();
      chk($sformatf("f%0d_c%0d_lz1", f, i), {b1.an, b1.seg}, e[21:11]);
      chk($sformatf("f%0d_c%0d_lz0", f, i), {b0.an, b0.seg}, e[10:0]);
      chk($sformatf("f%0d_c%0d_frame", f, i), {9'd0, b1.frame, b0.frame}, {9'd0, {2{i == 15}}});
      if (i == at) qd = nq;
    end
    shq = qd;
    shb = bl;
    f++;
  endtask
  initial begin
    qd = 16'h9675;
    do_reset();
    repeat (3) check_frame(16'h0, -1);
    qd = 16'h0007;
    repeat (2) check_frame(16'h0, -1);
    qd = 16'h00A0;
    repeat (2) check_frame(16'h0, -1);
    qd = 16'h9675;
    bl = 4'b1111;
    repeat (5) check_frame(16'h0, -1);
    bl = 4'b0001;
    repeat (4) check_frame(16'h0, -1);
    bl = 4'b0000;
    qd = 16'h1234;
    repeat (2) check_frame(16'h0, -1);
    check_frame(16'h5678, 5);
    check_frame(16'h0, -1);
    repeat (9) @(negedge clk);
    bl = 4'b1111;
    do_reset();
    repeat (3) check_frame(16'h0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clocks per digit slot (minimum 2).
REQ-002 Parameter BLINK_TICKS, default 250, digit slots per blink half-period (minimum 1).
REQ-003 Parameter LZ_BLANK, default 1, enables leading-zero suppression when 1.
REQ-004 Port clk  input  1  single system clock; all logic on the rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-low.
REQ-006 Port Qdata  input  16  four BCD digits from the counter chain; [3:0] is digit 0 (units, rightmost), [15:12] is digit 3.
REQ-007 Port blink  input  4  per-digit blink request; blink[n] applies to digit n.
REQ-008 Port seg  output  7  active-low segments; seg[0]=a through seg[6]=g.
REQ-009 Port an  output  4  active-low digit enables; an[n] drives digit n; at most one bit low at any time.
REQ-010 Port frame  output  1  one-cycle pulse when a new Qdata/blink snapshot is captured.

Function
REQ-011 Prescaler counts 0..SCAN_DIV-1 and wraps; "tick" is asserted in the cycle the prescaler equals SCAN_DIV-1.
REQ-012 Digit index idx (2 bits) advances on each tick, 0->1->2->3->0.
REQ-013 On a tick with idx==3, Qdata and blink are captured into shadow registers and frame pulses high for exactly that cycle; displayed data changes only at these frame boundaries.
REQ-014 Blink counter counts ticks 0..BLINK_TICKS-1; on the tick where it wraps, phase toggles; phase 1 = visible, phase 0 = blanked.
REQ-015 Decode (hex, {g..a} order): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; BCD codes A-F show a dash, 3F.
REQ-016 With LZ_BLANK=1, digit n (n=3,2,1) is suppressed when shadow digits n..3 are all zero; digit 0 is never suppressed.
REQ-017 For the current idx, an = ~(1<<idx) and seg = decode(shadow digit idx), unless the digit is suppressed (REQ-016) or (shadow blink[idx]==1 and phase==0).
REQ-018 In either of those cases, an = 4'b1111 and seg = 7'h7F.
REQ-019 seg and an are registered and reflect idx, shadow and phase with one cycle latency; no combinational path from Qdata or blink to outputs.
REQ-020 Tick, frame capture and phase toggle falling in the same cycle all take effect on the same edge; the new snapshot and new phase apply from the next output update.
REQ-021 Changes on Qdata/blink between frame boundaries are ignored; a value present for a single cycle is displayed only if it coincides with the capture cycle.

Reset
REQ-022 While rst==0 at a rising edge: prescaler=0, idx=0, blink counter=0, phase=1, shadow Qdata=0, shadow blink=0, frame=0, an=4'b1111, seg=7'h7F.
REQ-023 Reset overrides all other activity, including a coincident tick or capture, and may be asserted mid-frame.
REQ-024 In the first cycle after release, outputs update for idx 0 with shadow 0: seg=7'h40 and an=4'b1110.

Verification (SCAN_DIV=4, BLINK_TICKS=8, LZ_BLANK=1 unless stated)
REQ-025 Reset then Qdata=16'h9675 held, blink=0 -> frame pulses every 16 clocks; after first frame the slots show an=1110/seg=12, 1101/78, 1011/02, 0111/10, each lasting 4 clocks.
REQ-026 Qdata=16'h0007 -> digit 0 shows 78 on an=1110; digits 1-3 give an=1111, seg=7F; with LZ_BLANK=0, digits 1-3 show 40.
REQ-027 Qdata=16'h9675, blink=4'b1111 -> all digits visible for 8 ticks, then an=1111 for 8 ticks, repeating; with blink=4'b0001 only digit 0 blanks.
REQ-028 Qdata changes mid-frame (at idx 1) from 16'h1234 to 16'h5678 -> remaining slots of that frame still show 1234 digits; 5678 appears from the next frame.
REQ-029 Qdata=16'h00A0 -> digit 1 shows dash 3F; digit 0 shows 40; digits 2-3 suppressed.
REQ-030 rst low for 1 cycle at idx 2 mid-frame -> next edge gives an=1111, seg=7F, phase=1, frame=0; the cycle after release gives an=1110, seg=40.
